// File: rtl/pipe_rr_arbiter.sv
// -----------------------------------------------------------------------------
// pipe_rr_arbiter
//   Round-robin arbiter that shares one stallable pipeline input among NUM_REQ
//   requesters. It merges req_valid/req_data into pipe_validin/pipe_datain and
//   uses pipe_allowin as backpressure. While the pipeline stalls, the grant is
//   locked, so the data being offered cannot change underneath the stall.
//
//   The data path is combinational, so there is 0-cycle latency from a request
//   to the pipe_* outputs. Only the arbitration state is registered.
//
// Configuration macro:
//   ARB_XFER_CNT_EN  when defined, adds the xfer_cnt port. It is a saturating
//                    count of accepted transfers.
//
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   asynchronous active-low reset
//   req_valid     in   [NUM_REQ]         per-requester valid
//   req_data      in   [NUM_REQ*DATA_W]  requester i payload at [i*DATA_W +: DATA_W]
//   req_allow     out  [NUM_REQ]         one-hot: requester payload accepted this cycle
//   pipe_allowin  in   pipeline stage 1 can accept this cycle
//   pipe_validin  out  valid offered to the pipeline
//   pipe_datain   out  [DATA_W]          payload offered to the pipeline (0 when idle)
//   grant_id      out  [clog2(NUM_REQ)]  index offered (0 when pipe_validin=0)
//   xfer_cnt      out  [CNT_W]           accepted transfers (ARB_XFER_CNT_EN only)
// -----------------------------------------------------------------------------
module pipe_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_allow,
    input  logic                         pipe_allowin,
    output logic                         pipe_validin,
    output logic [DATA_W-1:0]            pipe_datain,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id
`ifdef ARB_XFER_CNT_EN
    ,
    output logic [CNT_W-1:0]             xfer_cnt
`endif
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [ID_W-1:0]   ptr_r, ptr_nxt_s;
    logic [ID_W-1:0]   lock_id_r, lock_nxt_s;
    logic [ID_W-1:0]   arb_win_s;
    logic [ID_W-1:0]   winner_s;
    logic              valid_s;
    logic              xfer_s;

    // (base + off) mod NUM_REQ without a divider; off is never above NUM_REQ-1.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        return (sum >= NUM_REQ) ? ID_W'(sum - NUM_REQ) : ID_W'(sum);
    endfunction

    // Rotating priority search. The loop scans from the farthest offset down
    // to offset 0, so the requester closest to ptr (inclusive) wins.
    always_comb begin
        arb_win_s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_add(ptr_r, k)]) begin
                arb_win_s = wrap_add(ptr_r, k);
            end else begin
                arb_win_s = arb_win_s;
            end
        end
    end

    // Winner selection, transfer detection and next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        lock_nxt_s  = lock_id_r;
        winner_s    = arb_win_s;
        valid_s     = 1'b0;
        case (state_r)
            ARB: begin
                winner_s = arb_win_s;
                valid_s  = |req_valid;
            end
            LOCK: begin
                // A locked grant ignores everyone else until it transfers.
                winner_s = lock_id_r;
                valid_s  = req_valid[lock_id_r];
            end
            default: begin
                winner_s = arb_win_s;
                valid_s  = 1'b0;
            end
        endcase

        xfer_s = valid_s & pipe_allowin;

        if (xfer_s) begin
            ptr_nxt_s   = wrap_add(winner_s, 1);
            state_nxt_s = ARB;
        end else if ((state_r == ARB) && valid_s) begin
            // Stalled offer: freeze it so the payload stays stable.
            state_nxt_s = LOCK;
            lock_nxt_s  = winner_s;
        end else if ((state_r == LOCK) && !valid_s) begin
            // Requester withdrew while locked. Re-arbitrate from the unchanged ptr.
            state_nxt_s = ARB;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Pipeline-facing outputs. These are forced idle while reset is asserted.
    always_comb begin
        pipe_validin = rst_n & valid_s;
        if (pipe_validin) begin
            pipe_datain = req_data[winner_s*DATA_W +: DATA_W];
            grant_id    = winner_s;
        end else begin
            pipe_datain = '0;
            grant_id    = '0;
        end
        if (rst_n && xfer_s) begin
            req_allow = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner_s;
        end else begin
            req_allow = '0;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ARB;
            ptr_r     <= '0;
            lock_id_r <= '0;
        end else begin
            state_r   <= state_nxt_s;
            ptr_r     <= ptr_nxt_s;
            lock_id_r <= lock_nxt_s;
        end
    end

`ifdef ARB_XFER_CNT_EN
    // Saturating transfer counter. It sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (xfer_s && (xfer_cnt != {CNT_W{1'b1}})) begin
            xfer_cnt <= xfer_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            xfer_cnt <= xfer_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pipe_rr_arbiter
//   Directed bench for pipe_rr_arbiter with NUM_REQ=4 and DATA_W=32.
//   Requester i always presents payload 32'h10+i.
//   Inputs change 1 ns after a rising edge, and outputs are checked 1 ns later.
// -----------------------------------------------------------------------------
module tb_pipe_rr_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_allow;
    logic         pipe_allowin;
    logic         pipe_validin;
    logic [31:0]  pipe_datain;
    logic [1:0]   grant_id;
`ifdef ARB_XFER_CNT_EN
    logic [3:0]   xfer_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pipe_rr_arbiter #(.NUM_REQ(4), .DATA_W(32), .CNT_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_allow    (req_allow),
        .pipe_allowin (pipe_allowin),
        .pipe_validin (pipe_validin),
        .pipe_datain  (pipe_datain),
        .grant_id     (grant_id)
`ifdef ARB_XFER_CNT_EN
        ,
        .xfer_cnt     (xfer_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Check a complete offer: valid, id, payload and allow vector.
    task automatic offer(input string tag, input logic v, input logic [1:0] id,
                         input logic [31:0] d, input logic [3:0] allow);
        chk({tag, ".valid"}, {31'd0, pipe_validin}, {31'd0, v});
        chk({tag, ".id"},    {30'd0, grant_id},     {30'd0, id});
        chk({tag, ".data"},  pipe_datain,           d);
        chk({tag, ".allow"}, {28'd0, req_allow},    {28'd0, allow});
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        req_data     = {32'h13, 32'h12, 32'h11, 32'h10};
        rst_n        = 1'b0;
        req_valid    = 4'b1111;
        pipe_allowin = 1'b1;

        // Reset: outputs are idle whatever the inputs, including across an edge.
        #1;
        offer("rst0", 1'b0, 2'd0, 32'h0, 4'b0000);
        tick;
        offer("rst1", 1'b0, 2'd0, 32'h0, 4'b0000);

        // Round robin with all requesters valid: the sequence is 0,1,2,3,0.
        rst_n = 1'b1;
        #1;
        offer("rr0", 1'b1, 2'd0, 32'h10, 4'b0001);
        tick; #1; offer("rr1", 1'b1, 2'd1, 32'h11, 4'b0010);
        tick; #1; offer("rr2", 1'b1, 2'd2, 32'h12, 4'b0100);
        tick; #1; offer("rr3", 1'b1, 2'd3, 32'h13, 4'b1000);
        tick; #1; offer("rr4", 1'b1, 2'd0, 32'h10, 4'b0001);
        tick;   // ptr = 1

        // Lock under stall on requester 2. Requester 0 arriving later must not steal the grant.
        req_valid = 4'b0100; pipe_allowin = 1'b0;
        #1; offer("lk0", 1'b1, 2'd2, 32'h12, 4'b0000);
        tick;
        req_valid = 4'b0101;
        #1; offer("lk1", 1'b1, 2'd2, 32'h12, 4'b0000);
        tick; #1; offer("lk2", 1'b1, 2'd2, 32'h12, 4'b0000);
        tick;
        pipe_allowin = 1'b1;
        #1; offer("lk3", 1'b1, 2'd2, 32'h12, 4'b0100);
        tick;
        req_valid = 4'b0001;
        #1; offer("lk4", 1'b1, 2'd0, 32'h10, 4'b0001);
        tick;   // ptr = 1

        // Skip idle requesters: with only 1 and 3 valid, grants go 1,3,1,3.
        req_valid = 4'b1010;
        #1; offer("sk0", 1'b1, 2'd1, 32'h11, 4'b0010);
        tick; #1; offer("sk1", 1'b1, 2'd3, 32'h13, 4'b1000);
        tick; #1; offer("sk2", 1'b1, 2'd1, 32'h11, 4'b0010);
        tick; #1; offer("sk3", 1'b1, 2'd3, 32'h13, 4'b1000);
        tick;   // ptr = 0

        // Withdrawal: lock on 3, then requester 3 drops its valid.
        req_valid = 4'b1000; pipe_allowin = 1'b0;
        #1; offer("wd0", 1'b1, 2'd3, 32'h13, 4'b0000);
        tick;
        req_valid = 4'b0010;
        #1; offer("wd1", 1'b0, 2'd0, 32'h0, 4'b0000);
        tick;   // back to ARB, ptr still 0
        req_valid = 4'b0110; pipe_allowin = 1'b1;
        #1; offer("wd2", 1'b1, 2'd1, 32'h11, 4'b0010);
        tick;   // ptr = 2

        // pipe_allowin high with nothing valid: no transfer and no pointer movement.
        req_valid = 4'b0000;
        #1; offer("idle", 1'b0, 2'd0, 32'h0, 4'b0000);
        tick;
        req_valid = 4'b1111;
        #1; offer("idle_after", 1'b1, 2'd2, 32'h12, 4'b0100);
        tick;   // ptr = 3

        // Reset while locked discards the lock, and arbitration restarts at 0.
        req_valid = 4'b0100; pipe_allowin = 1'b0;
        tick;   // locked on 2
        rst_n = 1'b0;
        #1; offer("rlk0", 1'b0, 2'd0, 32'h0, 4'b0000);
        tick;
        rst_n = 1'b1; req_valid = 4'b1111; pipe_allowin = 1'b1;
        #1; offer("rlk1", 1'b1, 2'd0, 32'h10, 4'b0001);
        tick;

`ifdef ARB_XFER_CNT_EN
        // Saturating counter: 17 transfers give 4'hF, which then holds; reset clears it.
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        #1; chk("cnt_rst", {28'd0, xfer_cnt}, 32'h0);
        for (int i = 0; i < 17; i++) tick;
        chk("cnt_sat", {28'd0, xfer_cnt}, 32'hF);
        tick;
        chk("cnt_hold", {28'd0, xfer_cnt}, 32'hF);
        rst_n = 1'b0;
        #1; chk("cnt_clr", {28'd0, xfer_cnt}, 32'h0);
        rst_n = 1'b1;
        tick;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
